uart_rx_axis: RTL and testbench

// - UART receiver (8N1-style, LSB first) that deserialises RX_i into bytes and presents

---
 rtl/uart_rx_axis.sv | 140 ++++++++++++++
 tb/tb_uart_rx_axis.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, LSB first) with an AXI-Stream master output.
// Bit timing is 8 prescale ticks per bit; decisions use a 2-flop synchronised copy of RX_i.
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  RX_i,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  frame_error_o,
    output logic                  overrun_error_o
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                  state_q;
    logic                    rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0]             presc_q, div_q;
    logic [2:0]              tcnt_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic                    ferr_q, ovr_q;

    logic [15:0]             presc_d;
    logic                    tick, start_edge, handshake;

    always_comb begin
        presc_d    = (prescale == 16'd0) ? 16'd1 : prescale;
        tick       = (div_q == 16'd0);
        start_edge = rx_prev_q & ~rx_s_q;
        handshake  = m_axis_tvalid & m_axis_tready;
    end

    assign busy_o          = (state_q != IDLE);
    assign frame_error_o   = ferr_q;
    assign overrun_error_o = ovr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            presc_q       <= 16'd1;
            div_q         <= 16'd0;
            tcnt_q        <= 3'd0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            ferr_q        <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            rx_meta_q <= RX_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;

            if (handshake)
                m_axis_tvalid <= 1'b0;

            if (state_q != IDLE)
                div_q <= tick ? presc_q - 16'd1 : div_q - 16'd1;

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q   <= START;
                        presc_q   <= presc_d;
                        div_q     <= presc_d - 16'd1;
                        tcnt_q    <= 3'd0;
                        bit_cnt_q <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 3'd1;
                        if (tcnt_q == 3'd3) begin
                            // Mid start bit: a high line here was only a glitch.
                            tcnt_q  <= 3'd0;
                            state_q <= rx_s_q ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 3'd1;
                        if (tcnt_q == 3'd7) begin
                            shreg_q <= {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                            if (bit_cnt_q == LAST_BIT)
                                state_q <= STOP;
                            else
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 3'd1;
                        if (tcnt_q == 3'd7) begin
                            if (rx_s_q) begin
                                state_q <= IDLE;
                                // A beat accepted this cycle frees the holding register.
                                if (!m_axis_tvalid || handshake) begin
                                    m_axis_tdata  <= shreg_q;
                                    m_axis_tvalid <= 1'b1;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: serial frames in, AXIS beats and error pulses checked.
module tb_uart_rx_axis;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        RX_i = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy_o, frame_error_o, overrun_error_o;

    logic        rdy_set = 1'b1;
    logic        tgl_en = 1'b0;
    logic        tgl_q = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;

    logic [7:0]  beats[$];
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          busy_cnt = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) tgl_q <= ~tgl_q;
    assign m_axis_tready = tgl_en ? tgl_q : rdy_set;

    uart_rx_axis #(.DATA_WIDTH(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .RX_i            (RX_i),
        .prescale        (prescale),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .busy_o          (busy_o),
        .frame_error_o   (frame_error_o),
        .overrun_error_o (overrun_error_o)
    );

    // Observe away from the active edge.
    always @(negedge clk_i) begin
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
        if (frame_error_o) ferr_cnt++;
        if (overrun_error_o) ovr_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        RX_i = v;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bt, input int stop_low);
        drive(1'b0, bt);
        for (int i = 0; i < 8; i++) drive(b[i], bt);
        if (stop_low > 0) drive(1'b0, bt * stop_low);
        drive(1'b1, bt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int b0, f0, o0, y0;
        logic [7:0] exp4 [4];
        exp4[0] = 8'h00; exp4[1] = 8'hFF; exp4[2] = 8'h5A; exp4[3] = 8'h81;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ferr", frame_error_o, 0);
        chk("rst_ovr", overrun_error_o, 0);
        rst_ni = 1'b1;
        drive(1'b1, 8);

        // 0x41 at prescale=1: busy spans 4 + 64 + 8 ticks of one clock each.
        b0 = beats.size(); f0 = ferr_cnt; o0 = ovr_cnt; y0 = busy_cnt;
        send_frame(8'h41, 8, 0);
        drive(1'b1, 16);
        chk("b41_count", beats.size() - b0, 1);
        chk("b41_data", beats[b0], 8'h41);
        chk("b41_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        chk("b41_busy_cycles", busy_cnt - y0, 76);
        chk("b41_idle", busy_o, 0);
        chk("b41_tvalid_clr", m_axis_tvalid, 0);

        // Short low glitch: detected, rejected at the half-bit sample.
        b0 = beats.size(); f0 = ferr_cnt; y0 = busy_cnt;
        drive(1'b0, 2);
        drive(1'b1, 20);
        chk("glitch_count", beats.size() - b0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_busy_cycles", busy_cnt - y0, 4);
        chk("glitch_idle", busy_o, 0);

        // prescale=0 behaves as 1; stop held low for 3 bit times.
        prescale = 16'd0;
        b0 = beats.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 8, 3);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        chk("ferr_no_beat", beats.size() - b0, 0);
        drive(1'b1, 16);
        send_frame(8'h3C, 8, 0);
        drive(1'b1, 16);
        chk("after_ferr_count", beats.size() - b0, 1);
        chk("after_ferr_data", beats[beats.size() - 1], 8'h3C);
        chk("after_ferr_ovr", ovr_cnt - o0, 0);

        // Back-pressure: second byte is dropped with an overrun pulse.
        prescale = 16'd1;
        rdy_set = 1'b0;
        b0 = beats.size(); o0 = ovr_cnt;
        send_frame(8'h55, 8, 0);
        send_frame(8'hAA, 8, 0);
        drive(1'b1, 8);
        chk("ovr_tdata", m_axis_tdata, 8'h55);
        chk("ovr_tvalid", m_axis_tvalid, 1);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        chk("ovr_no_beat", beats.size() - b0, 0);
        rdy_set = 1'b1;
        drive(1'b1, 4);
        chk("ovr_drain_count", beats.size() - b0, 1);
        chk("ovr_drain_data", beats[b0], 8'h55);
        chk("ovr_drain_tvalid", m_axis_tvalid, 0);

        // Four back-to-back frames at 32 clk/bit with tready toggling.
        prescale = 16'd4;
        tgl_en = 1'b1;
        b0 = beats.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) send_frame(exp4[i], 32, 0);
        drive(1'b1, 64);
        tgl_en = 1'b0;
        chk("b2b_count", beats.size() - b0, 4);
        for (int i = 0; i < 4; i++)
            if (beats.size() > b0 + i) chk($sformatf("b2b_data%0d", i), beats[b0 + i], exp4[i]);
        chk("b2b_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // Reset during data bit 3 aborts the frame.
        prescale = 16'd1;
        b0 = beats.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        drive(1'b0, 8);
        drive(1'b1, 24);
        drive(1'b0, 4);
        chk("mid_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_errs", {frame_error_o, overrun_error_o}, 0);
        drive(1'b1, 3);
        rst_ni = 1'b1;
        drive(1'b1, 16);
        send_frame(8'h7E, 8, 0);
        drive(1'b1, 16);
        chk("post_rst_count", beats.size() - b0, 1);
        chk("post_rst_data", beats[beats.size() - 1], 8'h7E);
        chk("post_rst_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
